// File: rtl/linear_tiled.sv
// Tiled int8 linear layer Y = requant(X * W) over two 64-bit memory bars.
// Contains the 8x8 outer-product accumulator (mm_systolic) that the sequencer feeds.

module mm_systolic #(
  parameter int WIDTH = 64,
  parameter int ARR   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               bar_valid,
  input  logic [WIDTH-1:0]   a_col,
  input  logic [WIDTH-1:0]   b_row,
  output logic signed [31:0] res [ARR][ARR]
);

  function automatic logic signed [31:0] mul8(input logic signed [7:0] a,
                                              input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    mul8 = {{16{p[15]}}, p};
  endfunction

  // Cell (i,j) accumulates X lane i times W lane j of the current reduction step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARR; i++)
        for (int j = 0; j < ARR; j++)
          res[i][j] <= 32'sd0;
    end else if (flush) begin
      for (int i = 0; i < ARR; i++)
        for (int j = 0; j < ARR; j++)
          res[i][j] <= 32'sd0;
    end else if (bar_valid) begin
      for (int i = 0; i < ARR; i++)
        for (int j = 0; j < ARR; j++)
          res[i][j] <= res[i][j] + mul8(a_col[WIDTH-1-8*i -: 8], b_row[WIDTH-1-8*j -: 8]);
    end else begin
      for (int i = 0; i < ARR; i++)
        for (int j = 0; j < ARR; j++)
          res[i][j] <= res[i][j];
    end
  end

endmodule

module linear_tiled #(
  parameter int WIDTH       = 64,
  parameter int ARR         = 8,
  parameter int DIM_W       = 8,
  parameter int RD_LAT      = 1,
  parameter int DRAIN       = 16,
  parameter int WEIGHT_BASE = 0,
  parameter int INPUT_BASE  = 2048,
  parameter int OUTPUT_BASE = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   cfg_m_tiles,
  input  logic [DIM_W-1:0]   cfg_n_tiles,
  input  logic [DIM_W+3:0]   cfg_k,
  input  logic [4:0]         cfg_shift,
  input  logic               cfg_transpose,
  output logic               busy,
  output logic               done,
  output logic               write_en_bar0,
  output logic [WIDTH-1:0]   data_in_bar0,
  output logic [31:0]        addr_bar0,
  input  logic [WIDTH-1:0]   data_out_bar0,
  output logic               write_en_bar1,
  output logic [WIDTH-1:0]   data_in_bar1,
  output logic [31:0]        addr_bar1,
  input  logic [WIDTH-1:0]   data_out_bar1
);

  typedef enum logic [2:0] {IDLE, FLUSH, READ, WAIT, WRITE, NEXT, DONE} state_t;

  localparam logic [31:0]      IN_BASE    = 32'(INPUT_BASE);
  localparam logic [31:0]      W_BASE     = 32'(WEIGHT_BASE);
  localparam logic [31:0]      OUT_BASE   = 32'(OUTPUT_BASE);
  localparam logic [DIM_W-1:0] D_ONE      = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W+3:0] K_ONE      = {{(DIM_W+3){1'b0}}, 1'b1};
  localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN - 1);

  state_t              state_r, state_nxt;
  logic [DIM_W-1:0]    m_r, n_r, mt_r, nt_r;
  logic [DIM_W+3:0]    k_r, k_cnt_r;
  logic [4:0]          shift_r;
  logic                trans_r;
  logic [7:0]          wait_cnt_r;
  logic [2:0]          write_cnt_r;
  logic [RD_LAT-1:0]   vld_r;
  logic [31:0]         m32, n32, mt32, nt32, stride_s, out_base_s;
  logic [2:0]          row_sel_s;
  logic [WIDTH-1:0]    word_s;
  logic                zero_cfg_s;
  logic signed [31:0]  res [ARR][ARR];

  // Round-half-up arithmetic shift in 33 bits, then clamp to int8.
  function automatic logic [7:0] requant(input logic signed [31:0] acc, input logic [4:0] sh);
    logic signed [32:0] sum;
    logic signed [32:0] q;
    sum = {acc[31], acc};
    if (sh != 5'd0) sum = sum + (33'sd1 <<< (sh - 5'd1));
    else            sum = sum;
    q = sum >>> sh;
    if (q > 33'sd127)       requant = 8'h7f;
    else if (q < -33'sd128) requant = 8'h80;
    else                    requant = q[7:0];
  endfunction

  assign write_en_bar0 = 1'b0;
  assign data_in_bar0  = {WIDTH{1'b0}};

  assign m32  = {{(32-DIM_W){1'b0}}, m_r};
  assign n32  = {{(32-DIM_W){1'b0}}, n_r};
  assign mt32 = {{(32-DIM_W){1'b0}}, mt_r};
  assign nt32 = {{(32-DIM_W){1'b0}}, nt_r};
  assign zero_cfg_s = (cfg_m_tiles == {DIM_W{1'b0}}) || (cfg_n_tiles == {DIM_W{1'b0}}) ||
                      (cfg_k == {(DIM_W+4){1'b0}});

  mm_systolic #(.WIDTH(WIDTH), .ARR(ARR)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (state_r == FLUSH),
    .bar_valid (vld_r[RD_LAT-1]),
    .a_col     (data_out_bar0),
    .b_row     (data_out_bar1),
    .res       (res)
  );

  // Output address, stride and word for the row (or column) written next.
  always_comb begin
    stride_s   = trans_r ? m32 : n32;
    out_base_s = trans_r ? OUT_BASE + (nt32 << 3'd3) * m32 + mt32
                         : OUT_BASE + (mt32 << 3'd3) * n32 + nt32;
    row_sel_s  = (state_r == WRITE) ? write_cnt_r + 3'd1 : 3'd0;
    word_s     = {WIDTH{1'b0}};
    for (int j = 0; j < ARR; j++) begin
      if (trans_r) word_s[WIDTH-1-8*j -: 8] = requant(res[j][row_sel_s], shift_r);
      else         word_s[WIDTH-1-8*j -: 8] = requant(res[row_sel_s][j], shift_r);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:  if (start) state_nxt = zero_cfg_s ? DONE : FLUSH;
             else       state_nxt = IDLE;
      FLUSH: state_nxt = READ;
      READ:  if (k_cnt_r == k_r - K_ONE) state_nxt = WAIT;
             else                        state_nxt = READ;
      WAIT:  if (wait_cnt_r == DRAIN_LAST) state_nxt = WRITE;
             else                          state_nxt = WAIT;
      WRITE: if (write_cnt_r == 3'd7) state_nxt = NEXT;
             else                     state_nxt = WRITE;
      NEXT:  if ((mt_r == m_r - D_ONE) && (nt_r == n_r - D_ONE)) state_nxt = DONE;
             else                                                state_nxt = FLUSH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-valid delay line matching the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {RD_LAT{1'b0}};
    end else begin
      vld_r[0] <= (state_r == READ);
      for (int i = 1; i < RD_LAT; i++) vld_r[i] <= vld_r[i-1];
    end
  end

  // State, counters, latched configuration and registered bar outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_r           <= {DIM_W{1'b0}};
      n_r           <= {DIM_W{1'b0}};
      mt_r          <= {DIM_W{1'b0}};
      nt_r          <= {DIM_W{1'b0}};
      k_r           <= {(DIM_W+4){1'b0}};
      k_cnt_r       <= {(DIM_W+4){1'b0}};
      shift_r       <= 5'd0;
      trans_r       <= 1'b0;
      wait_cnt_r    <= 8'd0;
      write_cnt_r   <= 3'd0;
      addr_bar0     <= IN_BASE;
      addr_bar1     <= W_BASE;
      write_en_bar1 <= 1'b0;
      data_in_bar1  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            m_r     <= cfg_m_tiles;
            n_r     <= cfg_n_tiles;
            k_r     <= cfg_k;
            shift_r <= cfg_shift;
            trans_r <= cfg_transpose;
            mt_r    <= {DIM_W{1'b0}};
            nt_r    <= {DIM_W{1'b0}};
          end else begin
            k_cnt_r <= {(DIM_W+4){1'b0}};
          end
        end
        FLUSH: begin
          k_cnt_r   <= {(DIM_W+4){1'b0}};
          addr_bar0 <= IN_BASE + mt32;
          addr_bar1 <= W_BASE + nt32;
        end
        READ: begin
          k_cnt_r    <= k_cnt_r + K_ONE;
          addr_bar0  <= addr_bar0 + m32;
          addr_bar1  <= addr_bar1 + n32;
          wait_cnt_r <= 8'd0;
        end
        WAIT: begin
          wait_cnt_r <= wait_cnt_r + 8'd1;
          if (state_nxt == WRITE) begin
            write_en_bar1 <= 1'b1;
            write_cnt_r   <= 3'd0;
            addr_bar1     <= out_base_s;
            data_in_bar1  <= word_s;
          end else begin
            write_en_bar1 <= 1'b0;
          end
        end
        WRITE: begin
          write_cnt_r <= write_cnt_r + 3'd1;
          if (write_cnt_r == 3'd7) begin
            write_en_bar1 <= 1'b0;
            data_in_bar1  <= {WIDTH{1'b0}};
          end else begin
            addr_bar1    <= addr_bar1 + stride_s;
            data_in_bar1 <= word_s;
          end
        end
        NEXT: begin
          if (nt_r == n_r - D_ONE) begin
            nt_r <= {DIM_W{1'b0}};
            mt_r <= mt_r + D_ONE;
          end else begin
            nt_r <= nt_r + D_ONE;
          end
        end
        DONE: write_en_bar1 <= 1'b0;
        default: write_en_bar1 <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_tiled.sv
// Directed bench for linear_tiled: identity tile, requant corners, a 4x16 tile job
// in both layouts against a reference product, zero-K job, ignored starts, reset in WRITE.

module tb_linear_tiled;

  localparam int RDL = 1;
  localparam int DRN = 16;
  localparam int IB  = 2048;
  localparam int WB  = 0;
  localparam int OB  = 4096;

  logic        clk, rst_n, start, cfg_transpose;
  logic [7:0]  cfg_m_tiles, cfg_n_tiles;
  logic [11:0] cfg_k;
  logic [4:0]  cfg_shift;
  logic        busy, done, write_en_bar0, write_en_bar1;
  logic [63:0] data_in_bar0, data_out_bar0, data_in_bar1, data_out_bar1;
  logic [31:0] addr_bar0, addr_bar1;

  linear_tiled #(.RD_LAT(RDL), .DRAIN(DRN), .WEIGHT_BASE(WB), .INPUT_BASE(IB),
                 .OUTPUT_BASE(OB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k(cfg_k),
    .cfg_shift(cfg_shift), .cfg_transpose(cfg_transpose),
    .busy(busy), .done(done),
    .write_en_bar0(write_en_bar0), .data_in_bar0(data_in_bar0),
    .addr_bar0(addr_bar0), .data_out_bar0(data_out_bar0),
    .write_en_bar1(write_en_bar1), .data_in_bar1(data_in_bar1),
    .addr_bar1(addr_bar1), .data_out_bar1(data_out_bar1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [0:8191];
  logic [63:0] p0 [0:RDL-1];
  logic [63:0] p1 [0:RDL-1];

  // Read-only memory with RDL cycles of latency on both bars
  always @(posedge clk) begin
    p0[0] <= mem[int'(addr_bar0 & 32'h1FFF)];
    p1[0] <= mem[int'(addr_bar1 & 32'h1FFF)];
    for (int i = 1; i < RDL; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign data_out_bar0 = p0[RDL-1];
  assign data_out_bar1 = p1[RDL-1];

  logic [63:0] outm [0:1023];
  int          wcnt [0:1023];
  int          nwr = 0, nbad = 0, ndone = 0;
  logic        clr;

  // Write log of the output region plus done-pulse counter
  always @(posedge clk) begin
    if (done === 1'b1) ndone <= ndone + 1;
    if (clr) begin
      for (int i = 0; i < 1024; i++) wcnt[i] <= 0;
      nwr  <= 0;
      nbad <= 0;
    end else if (write_en_bar1 === 1'b1) begin
      nwr <= nwr + 1;
      if (addr_bar1 >= 32'(OB) && addr_bar1 < 32'(OB + 1024)) begin
        outm[int'(addr_bar1 - 32'(OB))] <= data_in_bar1;
        wcnt[int'(addr_bar1 - 32'(OB))] <= wcnt[int'(addr_bar1 - 32'(OB))] + 1;
      end else begin
        nbad <= nbad + 1;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Pulses start and waits (bounded) for done; returns cycles since start and busy at cycle 1
  task automatic run_job(input int m, input int n, input int k, input int sh, input int tr,
                         input int poke, output int cyc, output logic b1);
    cfg_m_tiles = 8'(m); cfg_n_tiles = 8'(n); cfg_k = 12'(k);
    cfg_shift = 5'(sh); cfg_transpose = 1'(tr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b1  = busy;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (poke != 0 && cyc == 50) begin
        start = 1'b1; cfg_k = 12'd3; cfg_m_tiles = 8'd1; cfg_transpose = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] ref_rq(input longint v, input int sh);
    longint q, d;
    d = 64'sd1 <<< sh;
    q = (sh == 0) ? v : v + d / 2;
    if (q >= 0) q = q / d;
    else        q = -((-q + d - 1) / d);
    if (q > 127)       return 8'h7f;
    else if (q < -128) return 8'h80;
    else               return q[7:0];
  endfunction

  task automatic load_identity();
    logic [63:0] one;
    one = 64'h0100_0000_0000_0000;
    for (int k = 0; k < 8; k++) begin
      mem[IB + k] = one >> (8 * k);
      mem[WB + k] = one >> (8 * k);
    end
  endtask

  task automatic check_identity(input string tag);
    logic [63:0] e, one;
    one = 64'h0100_0000_0000_0000;
    check({tag, "_nwr"}, 64'(nwr), 64'd8);
    for (int i = 0; i < 8; i++) begin
      e = one >> (8 * i);
      check({tag, "_row"}, outm[i], e);
      check({tag, "_once"}, 64'(wcnt[i]), 64'd1);
    end
  endtask

  task automatic sat_job(input string tag, input logic [7:0] x, input logic [7:0] w,
                         input int sh, input logic [7:0] eb);
    int cyc;
    logic b1;
    mem[IB] = {8{x}};
    mem[WB] = {8{w}};
    clear_log();
    run_job(1, 1, 1, sh, 0, 0, cyc, b1);
    check({tag, "_cycles"}, 64'(cyc), 64'(1 + 1 + 1 + DRN + 9));
    @(negedge clk);
    for (int i = 0; i < 8; i++) check(tag, outm[i], {8{eb}});
  endtask

  int          xv [32][128];
  int          wv [128][128];
  longint      ex [32][128];

  initial begin
    int cyc, d0, n;
    logic b1;
    logic [63:0] wd;

    rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    cfg_m_tiles = 8'd0; cfg_n_tiles = 8'd0; cfg_k = 12'd0; cfg_shift = 5'd0;
    cfg_transpose = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we1", 64'(write_en_bar1), 64'd0);
    check("rst_addr0", 64'(addr_bar0), 64'(IB));
    check("rst_addr1", 64'(addr_bar1), 64'(WB));
    check("rst_data1", data_in_bar1, 64'd0);
    check("bar0_tied", {63'd0, write_en_bar0} | data_in_bar0, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity tile; a start during DONE must be ignored
    load_identity();
    clear_log();
    d0 = ndone;
    run_job(1, 1, 8, 0, 0, 0, cyc, b1);
    check("id_cycles", 64'(cyc), 64'd35);
    check("id_busy1", 64'(b1), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", 64'(busy), 64'd0);
    check("id_done_once", 64'(ndone - d0), 64'd1);
    check_identity("id");
    repeat (3) @(negedge clk);
    check("still_idle", 64'(busy), 64'd0);

    // Requantisation corners on uniform 1x1 tiles
    sat_job("sat_pos", 8'd10, 8'd20, 0, 8'h7f);
    sat_job("sat_neg", 8'd15, 8'hEC, 0, 8'h80);
    sat_job("rnd_p3", 8'd1, 8'd3, 1, 8'h02);
    sat_job("rnd_m3", 8'd1, 8'hFD, 1, 8'hFF);

    // 4x16 tiles, K=128, against a reference product
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 128; k++) xv[r][k] = int'($urandom_range(31, 0)) - 16;
    for (int k = 0; k < 128; k++)
      for (int c = 0; c < 128; c++) wv[k][c] = int'($urandom_range(31, 0)) - 16;
    for (int k = 0; k < 128; k++) begin
      for (int mt = 0; mt < 4; mt++) begin
        for (int l = 0; l < 8; l++) wd[63-8*l -: 8] = 8'(xv[8*mt+l][k]);
        mem[IB + k*4 + mt] = wd;
      end
      for (int nt = 0; nt < 16; nt++) begin
        for (int l = 0; l < 8; l++) wd[63-8*l -: 8] = 8'(wv[k][8*nt+l]);
        mem[WB + k*16 + nt] = wd;
      end
    end
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 128; c++) begin
        ex[r][c] = 0;
        for (int k = 0; k < 128; k++) ex[r][c] += longint'(xv[r][k]) * longint'(wv[k][c]);
      end

    for (int tr = 0; tr < 2; tr++) begin
      clear_log();
      d0 = ndone;
      run_job(4, 16, 128, 7, tr, (tr == 0) ? 1 : 0, cyc, b1);
      check(tr ? "tp_cycles" : "big_cycles", 64'(cyc), 64'd9857);
      @(negedge clk);
      check(tr ? "tp_nwr" : "big_nwr", 64'(nwr), 64'd512);
      check(tr ? "tp_bad_addr" : "big_bad_addr", 64'(nbad), 64'd0);
      check(tr ? "tp_done_once" : "big_done_once", 64'(ndone - d0), 64'd1);
      for (int a = 0; a < 512; a++) begin
        for (int l = 0; l < 8; l++) begin
          if (tr == 0) wd[63-8*l -: 8] = ref_rq(ex[a / 16][8*(a % 16) + l], 7);
          else         wd[63-8*l -: 8] = ref_rq(ex[8*(a % 4) + l][a / 4], 7);
        end
        check(tr ? "tp_word" : "big_word", outm[a], wd);
        check(tr ? "tp_once" : "big_once", 64'(wcnt[a]), 64'd1);
      end
    end

    // Zero reduction length: immediate done, no writes
    clear_log();
    d0 = ndone;
    run_job(1, 1, 0, 0, 0, 0, cyc, b1);
    check("k0_cycles", 64'(cyc), 64'd1);
    check("k0_busy", 64'(b1), 64'd1);
    @(negedge clk);
    check("k0_idle", 64'(busy), 64'd0);
    check("k0_nwr", 64'(nwr), 64'd0);
    check("k0_done_once", 64'(ndone - d0), 64'd1);

    // Reset while writing, then a clean rerun
    load_identity();
    clear_log();
    cfg_m_tiles = 8'd1; cfg_n_tiles = 8'd1; cfg_k = 12'd8; cfg_shift = 5'd0;
    cfg_transpose = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (write_en_bar1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_write", 64'(write_en_bar1), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_we1", 64'(write_en_bar1), 64'd0);
    check("mid_rst_addr0", 64'(addr_bar0), 64'(IB));
    check("mid_rst_addr1", 64'(addr_bar1), 64'(WB));
    check("mid_rst_data1", data_in_bar1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_we1", 64'(write_en_bar1), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    clear_log();
    run_job(1, 1, 8, 0, 0, 0, cyc, b1);
    check("rerun_cycles", 64'(cyc), 64'd35);
    @(negedge clk);
    check_identity("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
